// File: rtl/ltc2308_emu.sv
// ltc2308_emu -- device-side responder for the LTC2308 4-wire ADC bus.
//
// Sits on the far end of the bus from the ltc2308 controller. It watches
// CONVST/SCK/SDI, waits a fixed conversion time, and then shifts out a 12-bit
// sample MSB first on SDO. While that sample shifts out, it shifts in the
// controller's 6-bit config word. The sample is taken from a parallel
// per-channel input vector at the moment the conversion starts.
//
// Ports:
//   clk        in     1          system clock (same clock as the controller)
//   reset      in     1          synchronous, active-high reset
//   ADC_BUS    inout  4          [3]=SCK in, [2]=SDO out, [1]=SDI in, [0]=CONVST in
//   ch_data    in     NUM_CH*12  unsigned sample per channel, ch n at [n*12 +: 12]
//   conv_stb   out    1          1-clk pulse when a conversion starts
//   conv_ch    out    3          channel of current/last conversion
//   cfg_word   out    6          active config {S/D,O/S,S1,S0,UNI,SLP}
//   frame_done out    1          1-clk pulse on the 12th SCK rise of a frame
//   proto_err  out    1          1-clk pulse on a bus protocol violation
module ltc2308_emu #(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire  [3:0]           ADC_BUS,
  input  logic [NUM_CH*12-1:0] ch_data,
  output logic                 conv_stb,
  output logic [2:0]           conv_ch,
  output logic [5:0]           cfg_word,
  output logic                 frame_done,
  output logic                 proto_err
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [5:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_SHIFT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [11:0]   sr_reg, sr_next;
  logic [11:0]   snap_reg, snap_next;
  logic [5:0]    pend_reg, pend_next;
  logic [3:0]    bitcnt_reg, bitcnt_next;
  logic [5:0]    cfg_reg, cfg_next;
  logic [2:0]    ch_reg, ch_next;
  logic          stb_reg, stb_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          sck_q_reg, cnv_q_reg;

  logic sck, sdi, convst, rise, cnv, sdo;
  logic full_word, cfg_bad;
  logic [5:0] new_cfg;
  logic [2:0] new_ch;

  // Channels beyond NUM_CH read as zero so any 3-bit channel index is safe.
  logic [11:0] chan [0:7];
  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    if (gi < NUM_CH) begin : g_on
      assign chan[gi] = ch_data[gi*12 +: 12];
    end else begin : g_off
      assign chan[gi] = 12'h000;
    end
  end

  assign sck    = ADC_BUS[3];
  assign sdi    = ADC_BUS[1];
  assign convst = ADC_BUS[0];

  // The controller samples SDO one clk before it raises SCK. The shift takes
  // effect one clk after the rise, so the bit it sees is always stable.
  assign sdo        = (state_reg == ST_CONVERT) ? 1'b0 : sr_reg[11];
  assign ADC_BUS[2] = sdo;

  assign rise = sck & ~sck_q_reg;
  assign cnv  = convst & ~cnv_q_reg;

  // bitcnt is cleared at every CONVST. So bitcnt >= 6 means a complete config
  // word arrived since the previous conversion start.
  assign full_word = (bitcnt_reg >= 4'd6);
  assign new_cfg   = full_word ? pend_reg : cfg_reg;
  assign new_ch    = {new_cfg[3:2], new_cfg[4]};
  assign cfg_bad   = ~new_cfg[5] | ~new_cfg[1] | new_cfg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      sr_reg     <= '0;
      snap_reg   <= '0;
      pend_reg   <= '0;
      bitcnt_reg <= '0;
      cfg_reg    <= CFG_RESET;
      ch_reg     <= '0;
      stb_reg    <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      sck_q_reg  <= 1'b0;
      cnv_q_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sr_reg     <= sr_next;
      snap_reg   <= snap_next;
      pend_reg   <= pend_next;
      bitcnt_reg <= bitcnt_next;
      cfg_reg    <= cfg_next;
      ch_reg     <= ch_next;
      stb_reg    <= stb_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      sck_q_reg  <= sck;
      cnv_q_reg  <= convst;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sr_next     = sr_reg;
    snap_next   = snap_reg;
    pend_next   = pend_reg;
    bitcnt_next = bitcnt_reg;
    cfg_next    = cfg_reg;
    ch_next     = ch_reg;
    stb_next    = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;

    if (cnv) begin
      // CONVST takes priority over an SCK rise in the same clk; that rise is dropped.
      cfg_next    = new_cfg;
      ch_next     = new_ch;
      snap_next   = chan[new_ch];
      stb_next    = 1'b1;
      cnt_next    = CNT_LOAD;
      bitcnt_next = 4'd0;
      state_next  = ST_CONVERT;
      if (full_word && cfg_bad)
        err_next = 1'b1;
      if (state_reg == ST_CONVERT)
        err_next = 1'b1;
      if (state_reg == ST_SHIFT && bitcnt_reg != 4'd0)
        err_next = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          // Over-clocking past the 12th bit just drains zeros.
          if (rise)
            sr_next = {sr_reg[10:0], 1'b0};
        end
        ST_CONVERT: begin
          if (rise)
            err_next = 1'b1;
          if (cnt_reg == '0) begin
            sr_next     = snap_reg;
            bitcnt_next = 4'd0;
            state_next  = ST_SHIFT;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise) begin
            sr_next = {sr_reg[10:0], 1'b0};
            if (bitcnt_reg < 4'd6)
              pend_next = {pend_reg[4:0], sdi};
            if (bitcnt_reg != 4'd15)
              bitcnt_next = bitcnt_reg + 4'd1;
            if (bitcnt_reg == 4'd11) begin
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign conv_stb   = stb_reg;
  assign conv_ch    = ch_reg;
  assign cfg_word   = cfg_reg;
  assign frame_done = done_reg;
  assign proto_err  = err_reg;

endmodule

// File: tb/tb_ltc2308_emu.sv
// tb_ltc2308_emu -- directed, table-driven bench for ltc2308_emu.
// It plays the controller role on CONVST/SCK/SDI and reads SDO back. Pulse
// outputs are counted on the falling edge of clk.
module tb_ltc2308_emu;

  localparam int NCH = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            sck, sdi, convst;
  wire  [3:0]      adc_bus;
  logic [NCH*12-1:0] ch_data;
  logic            conv_stb, frame_done, proto_err;
  logic [2:0]      conv_ch;
  logic [5:0]      cfg_word;
  logic            sdo;

  assign adc_bus[3] = sck;
  assign adc_bus[1] = sdi;
  assign adc_bus[0] = convst;
  assign sdo        = adc_bus[2];

  ltc2308_emu #(.NUM_CH(NCH), .CONV_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ADC_BUS    (adc_bus),
    .ch_data    (ch_data),
    .conv_stb   (conv_stb),
    .conv_ch    (conv_ch),
    .cfg_word   (cfg_word),
    .frame_done (frame_done),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int stb_cnt = 0;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (proto_err)  pe_cnt++;
    if (conv_stb)   stb_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // CONVST pulse, high for two clks.
  task automatic do_cnv();
    @(negedge clk);
    convst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    convst = 1'b0;
  endtask

  // nrise SCK periods (1 clk high, 1 clk low). SDO is sampled before each rise.
  // The config bits go out MSB first.
  task automatic frame(input int nrise, input logic [5:0] cfg, output logic [15:0] word);
    word = '0;
    for (int i = 0; i < nrise; i++) begin
      @(negedge clk);
      sdi  = (i < 6) ? cfg[5-i] : 1'b0;
      word = {word[14:0], sdo};
      sck  = 1'b1;
      @(negedge clk);
      sck  = 1'b0;
    end
    sdi = 1'b0;
    wait_clk(2);
  endtask

  typedef struct {
    logic [5:0]  send;  // config shifted in during this frame
    logic [5:0]  cfg;   // cfg_word expected after this row's CONVST
    logic [2:0]  ch;
    logic [11:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] samples [NCH];
    logic [15:0] w;
    int pe0, fd0, st0;

    samples[0] = 12'hABC; samples[1] = 12'h123; samples[2] = 12'h456;
    samples[3] = 12'h789; samples[4] = 12'hDEF; samples[5] = 12'h321;
    for (int i = 0; i < NCH; i++) ch_data[i*12 +: 12] = samples[i];

    vecs[0] = '{6'b100110, 6'b110010, 3'd1, 12'h123, 1'b0};
    vecs[1] = '{6'b111110, 6'b100110, 3'd2, 12'h456, 1'b0};
    vecs[2] = '{6'b111010, 6'b111110, 3'd7, 12'h000, 1'b0};
    vecs[3] = '{6'b110110, 6'b111010, 3'd5, 12'h321, 1'b0};
    vecs[4] = '{6'b100010, 6'b110110, 3'd3, 12'h789, 1'b0};
    vecs[5] = '{6'b000010, 6'b100010, 3'd0, 12'hABC, 1'b0};
    vecs[6] = '{6'b100011, 6'b000010, 3'd0, 12'hABC, 1'b1};
    vecs[7] = '{6'b110000, 6'b100011, 3'd0, 12'hABC, 1'b1};
    vecs[8] = '{6'b110010, 6'b110000, 3'd1, 12'h123, 1'b1};
    vecs[9] = '{6'b100110, 6'b110010, 3'd1, 12'h123, 1'b0};

    sck = 1'b0; sdi = 1'b0; convst = 1'b0; reset = 1'b1;

    // Reset state
    wait_clk(3);
    chk("reset_sdo", sdo, 0);
    chk("reset_cfg", cfg_word, 6'b100010);
    chk("reset_ch", conv_ch, 0);
    chk("reset_stb", conv_stb, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_err", proto_err, 0);
    reset = 1'b0;
    wait_clk(2);

    // T1 first half: latency from CONVST to the MSB of ch0 (0xABC, MSB=1).
    @(negedge clk);
    convst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    convst = 1'b0;
    wait_clk(62);
    chk("lat_sdo_before", sdo, 0);
    @(negedge clk);
    chk("lat_sdo_msb", sdo, 1);
    chk("lat_stb_cnt", stb_cnt, 1);
    chk("lat_cfg", cfg_word, 6'b100010);
    chk("lat_ch", conv_ch, 0);
    fd0 = fd_cnt;
    frame(12, 6'b110010, w);
    chk("t1_data", w[11:0], 12'hABC);
    chk("t1_done", fd_cnt - fd0, 1);
    chk("t1_err", pe_cnt, 0);
    $display("first frame: ch=%0d data=%03h", conv_ch, w[11:0]);

    // Table of full frames
    for (int r = 0; r < 10; r++) begin
      pe0 = pe_cnt; st0 = stb_cnt;
      do_cnv();
      chk($sformatf("v%0d_stb", r), stb_cnt - st0, 1);
      chk($sformatf("v%0d_err", r), pe_cnt - pe0, vecs[r].err);
      chk($sformatf("v%0d_cfg", r), cfg_word, vecs[r].cfg);
      chk($sformatf("v%0d_ch", r), conv_ch, vecs[r].ch);
      wait_clk(80);
      fd0 = fd_cnt;
      frame(12, vecs[r].send, w);
      chk($sformatf("v%0d_data", r), w[11:0], vecs[r].data);
      chk($sformatf("v%0d_done", r), fd_cnt - fd0, 1);
      chk($sformatf("v%0d_err_after", r), pe_cnt - pe0, vecs[r].err);
      $display("vec %0d: cfg=%06b ch=%0d data=%03h", r, cfg_word, conv_ch, w[11:0]);
    end

    // T3: CONVST after 5 rises aborts the frame; the partial config is not used.
    do_cnv();
    chk("t3_cfg_first", cfg_word, 6'b100110);
    wait_clk(80);
    fd0 = fd_cnt;
    frame(5, 6'b111110, w);
    pe0 = pe_cnt;
    do_cnv();
    chk("t3_err", pe_cnt - pe0, 1);
    chk("t3_cfg_kept", cfg_word, 6'b100110);
    chk("t3_ch_kept", conv_ch, 2);
    wait_clk(80);
    frame(12, 6'b110010, w);
    chk("t3_data", w[11:0], 12'h456);
    chk("t3_done", fd_cnt - fd0, 1);
    $display("abort test: ch=%0d data=%03h", conv_ch, w[11:0]);

    // T4: SCK rise during conversion is flagged and ignored.
    do_cnv();
    chk("t4_ch", conv_ch, 1);
    pe0 = pe_cnt;
    wait_clk(10);
    @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    wait_clk(2);
    chk("t4_err", pe_cnt - pe0, 1);
    wait_clk(80);
    fd0 = fd_cnt;
    frame(12, 6'b100010, w);
    chk("t4_data", w[11:0], 12'h123);
    chk("t4_done", fd_cnt - fd0, 1);
    chk("t4_err_total", pe_cnt - pe0, 1);
    $display("early sck test: ch=%0d data=%03h", conv_ch, w[11:0]);

    // T5: 16 rises, with trailing zeros and a single frame_done.
    do_cnv();
    chk("t5_ch", conv_ch, 0);
    wait_clk(80);
    fd0 = fd_cnt; pe0 = pe_cnt;
    frame(16, 6'b111010, w);
    chk("t5_word", w, 16'hABC0);
    chk("t5_done", fd_cnt - fd0, 1);
    chk("t5_err", pe_cnt - pe0, 0);
    $display("16-bit frame: word=%04h", w);

    // T6: reset in the middle of a conversion.
    do_cnv();
    chk("t6_cfg_pre", cfg_word, 6'b111010);
    chk("t6_ch_pre", conv_ch, 5);
    wait_clk(18);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_sdo", sdo, 0);
    chk("t6_cfg", cfg_word, 6'b100010);
    chk("t6_ch", conv_ch, 0);
    reset = 1'b0;
    wait_clk(2);
    do_cnv();
    chk("t6_cfg_after", cfg_word, 6'b100010);
    wait_clk(80);
    frame(12, 6'b100010, w);
    chk("t6_data", w[11:0], 12'hABC);
    $display("post-reset frame: ch=%0d data=%03h", conv_ch, w[11:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
